// File: rtl/uart_tx_if.sv
// uart_tx_if: word handshake between a byte producer and the UART transmitter
interface uart_tx_if #(parameter int DATA_W = 8);
  logic              tx_en;
  logic [DATA_W-1:0] data;
  logic              ready;
  logic              busy;
  logic              done;
  logic              tx;
  modport master(output tx_en, data, input ready, busy, done, tx);
  modport slave(input tx_en, data, output ready, busy, done, tx);
endinterface

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: parametrised UART transmitter (width, bit period, parity, stop bits)
// Define UART_TX_HOLD_EN for a one-word holding register that allows back-to-back frames.
module uart_tx_cfg #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int DATA_W       = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input logic      clk,
  input logic      rst,
  uart_tx_if.slave bus
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t            state, state_nxt;
  logic [BW-1:0]     baud;
  logic [3:0]        bit_cnt;
  logic [DATA_W-1:0] shreg, hold, src;
  logic              par, hold_full, accept, bit_end, last_data, last_stop, load;
  if (CLKS_PER_BIT < 2 || DATA_W < 5 || DATA_W > 9 || PARITY_MODE < 0 || PARITY_MODE > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
    $error("uart_tx_cfg: illegal parameter value");
  end
  assign bit_end   = baud == BW'(CLKS_PER_BIT - 1);
  assign last_data = bit_cnt == 4'(DATA_W - 1);
  assign last_stop = bit_cnt == 4'(STOP_BITS - 1);
  assign accept    = bus.tx_en && bus.ready;
  assign load      = state_nxt == START && state != START;
  assign src       = hold_full ? hold : bus.data;
`ifdef UART_TX_HOLD_EN
  always_ff @(posedge clk)
    if (rst) hold_full <= 1'b0;
    else if (accept && state != IDLE) begin
      hold_full <= 1'b1;
      hold      <= bus.data;
    end else if (load) hold_full <= 1'b0;
`else
  assign hold_full = 1'b0;
  assign hold      = '0;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      state   <= IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      bus.done <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud     <= (state == IDLE || bit_end) ? '0 : baud + 1'b1;
      bit_cnt  <= state != state_nxt ? '0 : bit_cnt + 4'(bit_end);
      bus.done <= state == STOP && bit_end && last_stop;
    end
  // parity is fixed when the word is loaded so the shifter can consume its copy
  always_ff @(posedge clk)
    if (load) begin
      shreg <= src;
      par   <= ^src ^ (PARITY_MODE == 2);
    end else if (state == DATA && bit_end) shreg <= shreg >> 1;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept || hold_full) state_nxt = START;
      START:   if (bit_end) state_nxt = DATA;
      DATA:    if (bit_end && last_data) state_nxt = PARITY_MODE != 0 ? PARITY : STOP;
      PARITY:  if (bit_end) state_nxt = STOP;
      STOP:    if (bit_end && last_stop) state_nxt = hold_full ? START : IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    bus.busy = state != IDLE;
    bus.tx   = state == START ? 1'b0 : state == DATA ? shreg[0] : state == PARITY ? par : 1'b1;
`ifdef UART_TX_HOLD_EN
    bus.ready = ~hold_full;
`else
    bus.ready = state == IDLE;
`endif
  end
endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
- Parametrised UART transmitter; next generation of the fixed 8N1 UART_TX.
- Configurable data width, bit period, parity and stop-bit count.
- Standard tx_en/busy/done handshake, plus a ready output for upstream flow control.
- Sits between the byte-producing logic (CPU/bus bridge) and the serial pin.

Parameters:
- CLKS_PER_BIT, 10417, clock cycles per serial bit (9600 baud at 100 MHz); legal >= 2.
- DATA_W, 8, data bits per frame; legal 5..9.
- PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, number of stop bits; legal 1 or 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- tx_en  input  1  request to send data; sampled each rising edge.
- data  input  DATA_W  word to transmit; captured on acceptance.
- ready  output  1  tx_en is accepted this cycle when high.
- busy  output  1  a frame is on the line.
- done  output  1  one-cycle pulse at frame completion.
- tx  output  1  serial line; idle high.

Behaviour:
- Reset (rst=1 at a rising edge): tx=1, busy=0, done=0, ready=1, state=IDLE. Bit counter and baud counter are cleared.
- Reset mid-frame aborts the frame: tx=1 on the next edge and no done pulse.
- Acceptance: tx_en=1 and ready=1 at an edge. data is latched at that edge. Later changes on data have no effect on the frame.
- States and transitions:
  - IDLE -> START on acceptance.
  - START (tx=0) -> DATA.
  - DATA: DATA_W bits, LSB first.
  - DATA -> PARITY if PARITY_MODE != 0, else -> STOP.
  - PARITY -> STOP.
  - STOP (tx=1): STOP_BITS bits, then -> IDLE.
- Each bit is held exactly CLKS_PER_BIT cycles. The baud counter counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT).
- Latency: tx falls on the first edge after acceptance. busy rises on that same edge.
- Frame length = (1 + DATA_W + (PARITY_MODE != 0) + STOP_BITS) * CLKS_PER_BIT cycles.
- Parity:
  - Even: XOR of data bits, so total ones across data+parity is even.
  - Odd: inverted XOR.
- Completion: on the edge ending the last stop bit, the block enters IDLE, busy=0 and done=1 for exactly one cycle. tx stays 1.
- A tx_en during the done cycle is accepted, giving at least one idle cycle between frames.
- Without the optional feature, ready = ~busy. tx_en while busy is ignored with no side effect.
- tx_en held high continuously sends frames back-to-back, each separated by the one done/idle cycle.
- Illegal parameter values are a synthesis-time error, raised by a generate-time check.

Optional Feature:
- Macro UART_TX_HOLD_EN.
- Defined:
  - One-entry holding register; ready = ~hold_full.
  - Acceptance while busy loads the holding register.
  - At the end of the last stop bit with hold_full=1, the block goes straight to START with no idle cycle. done still pulses for one cycle, coincident with the first start-bit cycle, and busy stays 1. hold_full clears on that edge.
  - rst clears hold_full; a buffered word is discarded.
  - tx_en while hold_full=1 is ignored.
- Undefined: no holding register; behaviour as above with ready = ~busy.

Test Plan:
- Default params, data=8'hF0 with tx_en pulse, sample tx mid-bit every 10417 cycles -> bits {1,8'hF0,0} LSB first. done one cycle at cycle 104170 after acceptance; busy=0 then.
- Sweep 8'h00, FF, AA, 55, C1, 74, 72 with tx_en=1 -> each frame matches. With tx_en=0 and data varying -> tx stays 1 for 10 bit periods, busy=0, done=0.
- CLKS_PER_BIT=4, DATA_W=7, PARITY_MODE=2, STOP_BITS=2, data=7'h55 -> 11-bit frame 0,1,0,1,0,1,0,1,1(odd parity),1,1. done at cycle 44.
- PARITY_MODE=1, data=8'h07 -> parity bit 1. tx_en asserted mid-frame -> ignored, only one frame sent, ready=0 during frame.
- rst pulsed during DATA bit 3 -> tx=1 next edge, busy=0, no done. A new tx_en right after reset gives a clean full frame.
- UART_TX_HOLD_EN, CLKS_PER_BIT=4: accept 8'hA5 then 8'h3C while busy -> ready falls. Second start bit directly follows the stop bit (no idle cycle). Two done pulses; a third tx_en while hold_full is dropped.
